// File: rtl/game_controller.sv
// game_controller: tic-tac-toe game sequencer
// owns the board, turn order, scores and result display timing
module game_controller #(
  parameter int SCORE_W        = 4,
  parameter int REFRESH_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [3:0]         move_cell,
  input  logic               check_done,
  input  logic [5:0]         winning,
  output logic [2:0]         state,
  output logic [8:0][1:0]    main_vector,
  output logic               turn,
  output logic               move_accept,
  output logic               move_reject,
  output logic [1:0]         result,
  output logic [SCORE_W-1:0] score_x,
  output logic [SCORE_W-1:0] score_o,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_MOVE_X  = 3'b001,
    S_MOVE_O  = 3'b010,
    S_CHECK   = 3'b011,
    S_REFRESH = 3'b100,
    S_SCORE   = 3'b101
  } state_t;

  localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               st_q, st_d;
  logic [8:0][1:0]      board_q, board_d;
  logic                 turn_q, turn_d;
  logic                 start_q, start_d;
  logic                 acc_q, acc_d;
  logic                 rej_q, rej_d;
  logic                 over_q, over_d;
  logic [1:0]           res_q, res_d;
  logic [SCORE_W-1:0]   sx_q, sx_d;
  logic [SCORE_W-1:0]   so_q, so_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cell_free;
  logic                 restart;
  logic                 unused_line;

  // line index is only meaningful to the display
  assign unused_line = ^winning[2:0];

  // addressed cell exists and is empty
  always_comb begin
    cell_free = 1'b0;
    for (int i = 0; i < 9; i++)
      if (move_cell == 4'(i))
        cell_free = (board_q[i] == 2'b00);
  end

  // new_game only honoured between checks
  assign restart = new_game &&
    (st_q == S_IDLE || st_q == S_MOVE_X ||
     st_q == S_MOVE_O);

  // next-state and registered-output values
  always_comb begin
    st_d    = st_q;
    board_d = board_q;
    turn_d  = turn_q;
    start_d = start_q;
    acc_d   = 1'b0;
    rej_d   = 1'b0;
    res_d   = res_q;
    sx_d    = sx_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    if (restart) begin
      board_d = '0;
      res_d   = 2'b00;
      turn_d  = start_q;
      st_d    = start_q ? S_MOVE_O : S_MOVE_X;
    end else begin
      unique case (st_q)
        S_MOVE_X, S_MOVE_O: begin
          if (move_valid) begin
            if (cell_free) begin
              for (int i = 0; i < 9; i++)
                if (move_cell == 4'(i))
                  board_d[i] = (st_q == S_MOVE_O) ?
                    2'b01 : 2'b10;
              acc_d = 1'b1;
              st_d  = S_CHECK;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (check_done) begin
            if (winning[5]) begin
              st_d = S_SCORE;
            end else begin
              turn_d = ~turn_q;
              st_d   = turn_q ? S_MOVE_X : S_MOVE_O;
            end
          end
        end
        S_SCORE: begin
          st_d  = S_REFRESH;
          cnt_d = '0;
          unique case (1'b1)
            winning[5:3] == 3'b110: begin
              res_d = 2'b01;
              if (sx_q != SCORE_MAX) sx_d = sx_q + 1'b1;
            end
            winning[5:3] == 3'b111: begin
              res_d = 2'b10;
              if (so_q != SCORE_MAX) so_d = so_q + 1'b1;
            end
            default: res_d = 2'b11;
          endcase
        end
        S_REFRESH: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            board_d = '0;
            start_d = ~start_q;
            st_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    over_d = (st_d == S_SCORE) || (st_d == S_REFRESH);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      board_q <= '0;
      turn_q  <= 1'b0;
      start_q <= 1'b0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
      over_q  <= 1'b0;
      res_q   <= 2'b00;
      sx_q    <= '0;
      so_q    <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      board_q <= board_d;
      turn_q  <= turn_d;
      start_q <= start_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
      over_q  <= over_d;
      res_q   <= res_d;
      sx_q    <= sx_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = st_q;
  assign main_vector = board_q;
  assign turn        = turn_q;
  assign move_accept = acc_q;
  assign move_reject = rej_q;
  assign result      = res_q;
  assign score_x     = sx_q;
  assign score_o     = so_q;
  assign game_over   = over_q;

endmodule
